uart_cmd_responder: RTL and testbench

- Byte-level command/response engine for the UART link. It sits between the RX_RECV byte output and the TX_SEND byte input.
- It matches the incoming byte stream against NCMD parametrised command strings. On a full match it transmits the associated response string through a valid/ready handshake.
- This is the generalisation of the single fixed "VER" responder: multiple commands, parametrised lengths, inter-byte timeout, hit reporting, and an overflow/drop indication.

---
 rtl/uart_cmd_responder_if.sv | 30 +++
 rtl/uart_cmd_responder.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_cmd_responder.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_responder_if.sv
// uart_cmd_responder_if: RX byte strobe, TX valid/ready stream and
// status pulses of the command responder.
interface uart_cmd_responder_if #(
   parameter int DW   = 8,
   parameter int NCMD = 4
) ();
   localparam int IW = (NCMD > 1) ? $clog2(NCMD) : 1;

   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          busy;
   logic          cmd_hit;
   logic [IW-1:0] cmd_idx;
   logic          rx_drop;

   modport master (
      output rx_data, rx_valid, tx_ready,
      input  tx_data, tx_valid, busy,
      input  cmd_hit, cmd_idx, rx_drop
   );

   modport slave (
      input  rx_data, rx_valid, tx_ready,
      output tx_data, tx_valid, busy,
      output cmd_hit, cmd_idx, rx_drop
   );
endinterface

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: matches RX bytes against NCMD command strings and
// streams the paired reply. Option macro: UART_CMD_ERR_RESP_EN ("?\r\n").
module uart_cmd_responder #(
   parameter int DW     = 8,
   parameter int NCMD   = 4,
   parameter int MAXLEN = 8,
   parameter logic [NCMD*MAXLEN*DW-1:0] CMD_STR = '0,
   parameter logic [NCMD*8-1:0]         CMD_LEN = '0,
   parameter logic [NCMD*MAXLEN*DW-1:0] RSP_STR = '0,
   parameter logic [NCMD*8-1:0]         RSP_LEN = '0,
   parameter int TIMEOUT = 0
) (
   input logic CLK,
   input logic RST,
   uart_cmd_responder_if.slave bus
);
   localparam int PW = $clog2(MAXLEN + 1);
   localparam int IW = (NCMD > 1) ? $clog2(NCMD) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic {MATCH, SEND} state_t;

   state_t state, state_nx;

   logic [PW-1:0]   pos, pos_nx;
   logic [PW-1:0]   wrptr, wrptr_nx;
   logic [PW-1:0]   wr_inc, snd_len;
   logic [NCMD-1:0] alive, alive_nx;
   logic [NCMD-1:0] cand, cand0, comp, comp0, hitv;
   logic [TW-1:0]   tcnt, tcnt_nx;
   logic [IW-1:0]   widx, widx_nx;
   logic [IW-1:0]   cmd_idx, cmd_idx_nx;
   logic [DW-1:0]   tx_data, tx_data_nx, snd_chr;
   logic            tx_valid, tx_valid_nx;
   logic            busy, busy_nx;
   logic            cmd_hit, cmd_hit_nx;
   logic            rx_drop, rx_drop_nx;
   int              win;
`ifdef UART_CMD_ERR_RESP_EN
   logic            err, err_nx;
`endif

   function automatic logic [PW-1:0] cmd_len(input int i);
      return CMD_LEN[i*8 +: PW];
   endfunction

   function automatic logic [PW-1:0] rsp_len(input int i);
      return RSP_LEN[i*8 +: PW];
   endfunction

   // Character p of string i; explicit mux keeps p in range.
   function automatic logic [DW-1:0] str_chr(
      input logic [NCMD*MAXLEN*DW-1:0] s,
      input int                        i,
      input logic [PW-1:0]             p
   );
      logic [DW-1:0] c;
      c = '0;
      for (int j = 0; j < MAXLEN; j++)
         if (PW'(j) == p)
            c = s[(i*MAXLEN + j)*DW +: DW];
      return c;
   endfunction

`ifdef UART_CMD_ERR_RESP_EN
   function automatic logic [DW-1:0] err_chr(input logic [PW-1:0] p);
      logic [DW-1:0] c;
      if (p == PW'(0))
         c = DW'(8'h3f);
      else if (p == PW'(1))
         c = DW'(8'h0d);
      else
         c = DW'(8'h0a);
      return c;
   endfunction
`endif

   // Candidate sets: continue at pos, or restart with this byte as char 0.
   always_comb begin
      cand  = '0;
      cand0 = '0;
      comp  = '0;
      comp0 = '0;
      for (int i = 0; i < NCMD; i++) begin
         cand[i]  = alive[i] && (cmd_len(i) > pos) &&
                    (str_chr(CMD_STR, i, pos) == bus.rx_data);
         comp[i]  = cand[i] && (cmd_len(i) == pos + PW'(1));
         cand0[i] = (cmd_len(i) != '0) &&
                    (str_chr(CMD_STR, i, '0) == bus.rx_data);
         comp0[i] = cand0[i] && (cmd_len(i) == PW'(1));
      end
      if (|comp)
         hitv = comp;
      else if (|cand)
         hitv = '0;
      else
         hitv = comp0;
      win = 0;
      for (int i = NCMD - 1; i >= 0; i--)
         if (hitv[i])
            win = i;
   end

   // Reply byte source for the transfer after the current one.
   always_comb begin
      wr_inc  = wrptr + PW'(1);
      snd_len = rsp_len(int'(widx));
      snd_chr = str_chr(RSP_STR, int'(widx), wr_inc);
`ifdef UART_CMD_ERR_RESP_EN
      if (err) begin
         snd_len = PW'(3);
         snd_chr = err_chr(wr_inc);
      end
`endif
   end

   // Next-state and output logic of the MATCH/SEND machine.
   always_comb begin
      state_nx    = state;
      pos_nx      = pos;
      alive_nx    = alive;
      tcnt_nx     = tcnt;
      wrptr_nx    = wrptr;
      widx_nx     = widx;
      cmd_idx_nx  = cmd_idx;
      tx_data_nx  = tx_data;
      tx_valid_nx = tx_valid;
      busy_nx     = busy;
      cmd_hit_nx  = 1'b0;
      rx_drop_nx  = 1'b0;
`ifdef UART_CMD_ERR_RESP_EN
      err_nx      = err;
`endif
      unique case (state)
         MATCH: begin
            if (bus.rx_valid) begin
               tcnt_nx = '0;
               if (|hitv) begin
                  cmd_hit_nx = 1'b1;
                  cmd_idx_nx = IW'(win);
                  pos_nx     = '0;
                  alive_nx   = '1;
                  if (rsp_len(win) != '0) begin
                     state_nx    = SEND;
                     busy_nx     = 1'b1;
                     tx_valid_nx = 1'b1;
                     wrptr_nx    = '0;
                     widx_nx     = IW'(win);
                     tx_data_nx  = str_chr(RSP_STR, win, '0);
`ifdef UART_CMD_ERR_RESP_EN
                     err_nx      = 1'b0;
`endif
                  end
               end else if (|cand) begin
                  alive_nx = cand;
                  pos_nx   = pos + PW'(1);
               end else if (|cand0) begin
                  alive_nx = cand0;
                  pos_nx   = PW'(1);
               end else begin
                  alive_nx = '1;
                  pos_nx   = '0;
`ifdef UART_CMD_ERR_RESP_EN
                  if (bus.rx_data == DW'(8'h0a)) begin
                     state_nx    = SEND;
                     busy_nx     = 1'b1;
                     tx_valid_nx = 1'b1;
                     wrptr_nx    = '0;
                     err_nx      = 1'b1;
                     tx_data_nx  = err_chr('0);
                  end
`endif
               end
            end else if (TIMEOUT != 0 && pos != '0) begin
               if (tcnt == TW'(TIMEOUT - 1)) begin
                  pos_nx   = '0;
                  alive_nx = '1;
                  tcnt_nx  = '0;
               end else begin
                  tcnt_nx = tcnt + TW'(1);
               end
            end
         end
         SEND: begin
            if (bus.rx_valid)
               rx_drop_nx = 1'b1;
            if (tx_valid && bus.tx_ready) begin
               if (wrptr == snd_len - PW'(1)) begin
                  state_nx    = MATCH;
                  tx_valid_nx = 1'b0;
                  busy_nx     = 1'b0;
                  wrptr_nx    = '0;
               end else begin
                  wrptr_nx   = wr_inc;
                  tx_data_nx = snd_chr;
               end
            end
         end
         default: state_nx = MATCH;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= MATCH;
         pos      <= '0;
         alive    <= '1;
         tcnt     <= '0;
         wrptr    <= '0;
         widx     <= '0;
         cmd_idx  <= '0;
         tx_data  <= '0;
         tx_valid <= 1'b0;
         busy     <= 1'b0;
         cmd_hit  <= 1'b0;
         rx_drop  <= 1'b0;
`ifdef UART_CMD_ERR_RESP_EN
         err      <= 1'b0;
`endif
      end else begin
         state    <= state_nx;
         pos      <= pos_nx;
         alive    <= alive_nx;
         tcnt     <= tcnt_nx;
         wrptr    <= wrptr_nx;
         widx     <= widx_nx;
         cmd_idx  <= cmd_idx_nx;
         tx_data  <= tx_data_nx;
         tx_valid <= tx_valid_nx;
         busy     <= busy_nx;
         cmd_hit  <= cmd_hit_nx;
         rx_drop  <= rx_drop_nx;
`ifdef UART_CMD_ERR_RESP_EN
         err      <= err_nx;
`endif
      end
   end

   assign bus.tx_data  = tx_data;
   assign bus.tx_valid = tx_valid;
   assign bus.busy     = busy;
   assign bus.cmd_hit  = cmd_hit;
   assign bus.cmd_idx  = cmd_idx;
   assign bus.rx_drop  = rx_drop;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb_uart_cmd_responder: directed bench, three commands, TIMEOUT=100;
// error-reply expectations follow UART_CMD_ERR_RESP_EN.
module tb_uart_cmd_responder;
   localparam int NCMD   = 3;
   localparam int MAXLEN = 8;

   // cmd0 "VER\r\n", cmd1 "ID\r\n", cmd2 "!" (char 0 in the low byte)
   localparam logic [NCMD*MAXLEN*8-1:0] CMD_STR = {
      64'h00000000_00000021,
      64'h00000000_0A0D4449,
      64'h000000_0A0D524556
   };
   localparam logic [NCMD*8-1:0] CMD_LEN = {8'd1, 8'd4, 8'd5};
   // rsp0 "V1.0\r\n", rsp1 "AB\r\n", rsp2 empty
   localparam logic [NCMD*MAXLEN*8-1:0] RSP_STR = {
      64'h00000000_00000000,
      64'h00000000_0A0D4241,
      64'h0000_0A0D302E3156
   };
   localparam logic [NCMD*8-1:0] RSP_LEN = {8'd0, 8'd4, 8'd6};

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   uart_cmd_responder_if #(.DW(8), .NCMD(NCMD)) bus ();

   uart_cmd_responder #(
      .DW(8), .NCMD(NCMD), .MAXLEN(MAXLEN),
      .CMD_STR(CMD_STR), .CMD_LEN(CMD_LEN),
      .RSP_STR(RSP_STR), .RSP_LEN(RSP_LEN),
      .TIMEOUT(100)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
   );

   int errs = 0;
   int checks = 0;

   int hits = 0;
   int drops = 0;
   int txn = 0;
   int stalls = 0;
   int holdbad = 0;
   logic [7:0] txbuf [256];
   logic stall = 1'b0;
   logic [7:0] stall_d = '0;

   int h0, d0, t0, s0;
   logic [3:0] pat = 4'b1111;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Observe transfers, pulses and stalled-output stability mid-cycle.
   always @(negedge clk) begin
      if (stall) begin
         stalls <= stalls + 1;
         if (!bus.tx_valid || bus.tx_data != stall_d)
            holdbad <= holdbad + 1;
      end
      stall   <= bus.tx_valid && !bus.tx_ready;
      stall_d <= bus.tx_data;
      if (bus.tx_valid && bus.tx_ready) begin
         txbuf[txn % 256] <= bus.tx_data;
         txn <= txn + 1;
      end
      if (bus.cmd_hit)
         hits <= hits + 1;
      if (bus.rx_drop)
         drops <= drops + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic snap();
      h0 = hits;
      d0 = drops;
      t0 = txn;
      s0 = stalls;
   endtask

   // Send n bytes, first byte in the most significant used position.
   task automatic send_str(input logic [63:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         bus.rx_data  = v[8*(n-1-i) +: 8];
         bus.rx_valid = 1'b1;
         tick(1);
      end
      bus.rx_valid = 1'b0;
   endtask

   task automatic drain(input string tag, input int budget);
      for (int k = 0; k < budget && (bus.busy || bus.tx_valid); k++) begin
         bus.tx_ready = pat[k % 4];
         tick(1);
      end
      bus.tx_ready = 1'b1;
      check({tag, "_busy_end"}, 32'(bus.busy), 0);
      check({tag, "_valid_end"}, 32'(bus.tx_valid), 0);
   endtask

   task automatic expect_tx(input string tag,
                            input logic [63:0] exp,
                            input int n);
      check({tag, "_count"}, 32'(txn - t0), 32'(n));
      for (int i = 0; i < n; i++)
         check({tag, "_byte"}, 32'(txbuf[(t0 + i) % 256]),
               32'(exp[8*(n-1-i) +: 8]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.rx_data  = '0;
      bus.rx_valid = 1'b0;
      bus.tx_ready = 1'b1;
      tick(3);
      rst = 1'b0;
      check("rst_tx_valid", 32'(bus.tx_valid), 0);
      check("rst_tx_data", 32'(bus.tx_data), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_cmd_hit", 32'(bus.cmd_hit), 0);
      check("rst_cmd_idx", 32'(bus.cmd_idx), 0);
      check("rst_rx_drop", 32'(bus.rx_drop), 0);
      tick(2);

      // VER\r\n with ready high
      snap();
      send_str(64'h56_45_52_0D_0A, 5);
      check("ver_hit", 32'(bus.cmd_hit), 1);
      check("ver_idx", 32'(bus.cmd_idx), 0);
      check("ver_valid", 32'(bus.tx_valid), 1);
      check("ver_busy", 32'(bus.busy), 1);
      check("ver_first", 32'(bus.tx_data), 32'h56);
      drain("ver", 40);
      expect_tx("ver", 64'h56_31_2E_30_0D_0A, 6);
      check("ver_hits", 32'(hits - h0), 1);
      tick(2);

      // restart re-evaluation
      snap();
      send_str(64'h56_56_45_52_0D_0A, 6);
      check("vver_hit", 32'(bus.cmd_hit), 1);
      check("vver_idx", 32'(bus.cmd_idx), 0);
      drain("vver", 40);
      expect_tx("vver", 64'h56_31_2E_30_0D_0A, 6);
      tick(2);

      // ID\r\n with ready pattern 1,0,0,1
      snap();
      pat = 4'b1001;
      send_str(64'h49_44_0D_0A, 4);
      check("id_idx", 32'(bus.cmd_idx), 1);
      drain("id", 40);
      pat = 4'b1111;
      expect_tx("id", 64'h41_42_0D_0A, 4);
      check("id_stalls", 32'(stalls - s0), 4);
      check("id_hold", 32'(holdbad), 0);
      check("id_hits", 32'(hits - h0), 1);
      tick(2);

      // length-1 command after restart, empty reply
      snap();
      send_str(64'h56_21, 2);
      check("bang_hit", 32'(bus.cmd_hit), 1);
      check("bang_idx", 32'(bus.cmd_idx), 2);
      check("bang_busy", 32'(bus.busy), 0);
      tick(3);
      check("bang_held", 32'(bus.cmd_idx), 2);
      check("bang_pulse", 32'(bus.cmd_hit), 0);
      check("bang_hits", 32'(hits - h0), 1);
      expect_tx("bang", 64'h0, 0);

      // idle 100 cycles discards the partial match
      snap();
      send_str(64'h56_45, 2);
      tick(100);
      send_str(64'h52_0D_0A, 3);
      tick(2);
      drain("tmo", 20);
`ifdef UART_CMD_ERR_RESP_EN
      expect_tx("tmo", 64'h3F_0D_0A, 3);
`else
      expect_tx("tmo", 64'h0, 0);
`endif
      check("tmo_hits", 32'(hits - h0), 0);
      tick(2);

      // idle 50 cycles keeps it
      snap();
      send_str(64'h56_45, 2);
      tick(50);
      send_str(64'h52_0D_0A, 3);
      check("short_hit", 32'(bus.cmd_hit), 1);
      check("short_idx", 32'(bus.cmd_idx), 0);
      drain("short", 40);
      expect_tx("short", 64'h56_31_2E_30_0D_0A, 6);
      tick(2);

      // bytes during SEND are dropped
      snap();
      bus.tx_ready = 1'b0;
      send_str(64'h56_45_52_0D_0A, 5);
      send_str(64'h49_44_0D_0A, 4);
      tick(1);
      check("drop_count", 32'(drops - d0), 4);
      check("drop_busy", 32'(bus.busy), 1);
      drain("drop", 40);
      expect_tx("drop", 64'h56_31_2E_30_0D_0A, 6);
      check("drop_hits", 32'(hits - h0), 1);
      tick(2);
      snap();
      send_str(64'h44_0D_0A, 3);
      tick(2);
      drain("drop_pos", 20);
      check("drop_pos_hits", 32'(hits - h0), 0);
`ifdef UART_CMD_ERR_RESP_EN
      expect_tx("drop_pos", 64'h3F_0D_0A, 3);
`else
      expect_tx("drop_pos", 64'h0, 0);
`endif
      tick(2);

      // reset in the middle of a reply
      snap();
      send_str(64'h56_45_52_0D_0A, 5);
      tick(2);
      rst = 1'b1;
      tick(1);
      check("rmid_valid", 32'(bus.tx_valid), 0);
      check("rmid_busy", 32'(bus.busy), 0);
      rst = 1'b0;
      tick(10);
      check("rmid_quiet", 32'(bus.tx_valid), 0);
      expect_tx("rmid", 64'h56_31_2E, 3);

      // unrecognised line ending in LF
      snap();
      send_str(64'h58_59_5A_0A, 4);
      check("err_hit", 32'(bus.cmd_hit), 0);
`ifdef UART_CMD_ERR_RESP_EN
      check("err_valid", 32'(bus.tx_valid), 1);
      check("err_first", 32'(bus.tx_data), 32'h3F);
      drain("err", 20);
      expect_tx("err", 64'h3F_0D_0A, 3);
`else
      check("err_valid", 32'(bus.tx_valid), 0);
      tick(5);
      expect_tx("err", 64'h0, 0);
`endif
      check("err_hits", 32'(hits - h0), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
